// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read data and full/empty flags.
// Define FIFO_SYNC_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  full
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_accept, rd_accept;

  // Flags decode straight from the pointers; the MSB is the wrap bit that
  // separates "same slot, nothing stored" from "same slot, every slot stored".
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_accept = cs & wr_en & ~full;
  assign rd_accept = cs & rd_en & ~empty;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      data_out_d = mem[rd_ptr_q[AW-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_q;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset: records any rejected access attempt.
  always_comb begin
    overflow_d  = overflow_q  | (cs & wr_en & full);
    underflow_d = underflow_q | (cs & rd_en & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (depth 8, 32-bit words).
// Covers reset, fill/drop-on-full, wrap ordering, empty reads, simultaneous access.
module tb_fifo_sync;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        empty;
  logic        full;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int vectors;
  int miscompares;

  fifo_sync #(.FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
`else
    .full     (full)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let one rising edge act,
  // and return at the next falling edge so outputs are sampled mid-cycle.
  task automatic step(input logic c, input logic w, input logic r, input logic [31:0] d);
    cs      = c;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    cs    = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_rd [6];
    vectors     = 0;
    miscompares = 0;
    cs      = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    rst_n   = 1'b1;

    // Reset
    #2 rst_n = 1'b0;
    #10;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", data_out, 32'h0);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_full", 32'(full), 32'd0);
    check("idle_dout", data_out, 32'h0);

    // Fill with 1..8
    step(1'b1, 1'b1, 1'b0, 32'h1);
    check("fill1_empty", 32'(empty), 32'd0);
    check("fill1_full", 32'(full), 32'd0);
    for (int i = 2; i <= 7; i++) step(1'b1, 1'b1, 1'b0, 32'(i));
    check("fill7_full", 32'(full), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h8);
    check("fill8_full", 32'(full), 32'd1);
    check("fill8_dout", data_out, 32'h0);

    // Write while full is dropped
    step(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_dout", data_out, 32'h0);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_udf_clear", 32'(underflow), 32'd0);
`endif

    // Read four in order
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0);
      check($sformatf("rd%0d_dout", i), data_out, 32'(i));
    end
    check("rd4_full", 32'(full), 32'd0);
    check("rd4_empty", 32'(empty), 32'd0);

    // Two writes that wrap the write pointer, then drain six
    step(1'b1, 1'b1, 1'b0, 32'hAABBCCDD);
    step(1'b1, 1'b1, 1'b0, 32'h11223344);
    check("wrap_full", 32'(full), 32'd0);
    exp_rd[0] = 32'h5;
    exp_rd[1] = 32'h6;
    exp_rd[2] = 32'h7;
    exp_rd[3] = 32'h8;
    exp_rd[4] = 32'hAABBCCDD;
    exp_rd[5] = 32'h11223344;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0);
      check($sformatf("drain%0d_dout", i), data_out, exp_rd[i]);
      check($sformatf("drain%0d_empty", i), 32'(empty), (i == 5) ? 32'd1 : 32'd0);
    end

    // Read while empty holds data_out
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("udf_dout", data_out, 32'h11223344);
    check("udf_empty", 32'(empty), 32'd1);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    check("udf_flag", 32'(underflow), 32'd1);
`endif

    // Simultaneous read+write with three entries
    step(1'b1, 1'b1, 1'b0, 32'hA1);
    step(1'b1, 1'b1, 1'b0, 32'hA2);
    step(1'b1, 1'b1, 1'b0, 32'hA3);
    step(1'b1, 1'b1, 1'b1, 32'hA4);
    check("rw3_dout", data_out, 32'hA1);
    check("rw3_empty", 32'(empty), 32'd0);
    check("rw3_full", 32'(full), 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'hFF);
    check("cs0_dout", data_out, 32'hA1);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("rw3_rd1", data_out, 32'hA2);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("rw3_rd2", data_out, 32'hA3);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("rw3_rd3", data_out, 32'hA4);
    check("rw3_drained", 32'(empty), 32'd1);

    // Simultaneous read+write when full: only the read happens
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'hB0 + 32'(i));
    check("full2_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'hCC);
    check("rwfull_dout", data_out, 32'hB0);
    check("rwfull_full", 32'(full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0);
      check($sformatf("rwfull_rd%0d", i), data_out, 32'hB0 + 32'(i));
    end
    check("rwfull_empty", 32'(empty), 32'd1);

    // Simultaneous read+write when empty: only the write, no bypass
    step(1'b1, 1'b1, 1'b1, 32'hDD);
    check("rwempty_dout", data_out, 32'hB7);
    check("rwempty_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("rwempty_rd", data_out, 32'hDD);

    // Asynchronous reset mid-operation
    step(1'b1, 1'b1, 1'b0, 32'h77);
    step(1'b1, 1'b1, 1'b0, 32'h88);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_dout", data_out, 32'h0);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_udf", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("postrst_dout", data_out, 32'h0);
    check("postrst_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
